// File: rtl/axi_rd_sram_bridge.sv
// AXI4 read-only slave bridging single-beat-per-fetch bursts onto a 1-cycle-latency SRAM.
// WRAP bursts are served only when AXI_RD_SRAM_BRIDGE_WRAP_EN is defined, otherwise answered with SLVERR.
module axi_rd_sram_bridge #(
  parameter int RAM_ADDR_W = 14,
  parameter int AXI_ID_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  axi_arvalid_i,
  input  logic [31:0]           axi_araddr_i,
  input  logic [AXI_ID_W-1:0]   axi_arid_i,
  input  logic [7:0]            axi_arlen_i,
  input  logic [1:0]            axi_arburst_i,
  output logic                  axi_arready_o,
  output logic                  axi_rvalid_o,
  output logic [31:0]           axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  output logic [AXI_ID_W-1:0]   axi_rid_o,
  output logic                  axi_rlast_o,
  input  logic                  axi_rready_i,
  output logic                  ram_rd_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  input  logic [31:0]           ram_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [AXI_ID_W-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic                  first_q, first_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  ar_legal;
  logic                  last_beat;
  logic [31:0]           wrap_mask;
  logic [31:0]           addr_nxt;

  always_comb begin
    ar_legal = 1'b1;
    case (axi_arburst_i)
      2'b11: ar_legal = 1'b0;
      2'b10: begin
`ifdef AXI_RD_SRAM_BRIDGE_WRAP_EN
        ar_legal = (axi_arlen_i == 8'd1) || (axi_arlen_i == 8'd3) ||
                   (axi_arlen_i == 8'd7) || (axi_arlen_i == 8'd15);
`else
        ar_legal = 1'b0;
`endif
      end
      default: ar_legal = 1'b1;
    endcase
  end

  // (len+1)*4-1 is simply len with two low ones appended
  assign wrap_mask = {22'd0, len_q, 2'b11};

  always_comb begin
    addr_nxt = addr_q + 32'd4;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
      default: addr_nxt = addr_q + 32'd4;
    endcase
  end

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    err_d   = err_q;
    first_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (axi_arvalid_i) begin
          addr_d  = axi_araddr_i;
          id_d    = axi_arid_i;
          len_d   = axi_arlen_i;
          burst_d = axi_arburst_i;
          err_d   = !ar_legal;
          cnt_d   = 8'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        first_d = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        // SRAM output is only valid in the first DATA cycle; keep a copy for stalls
        if (first_q) begin
          rdata_d = ram_data_i;
        end
        if (axi_rready_i) begin
          cnt_d   = cnt_q + 8'd1;
          addr_d  = addr_nxt;
          state_d = last_beat ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      first_q <= first_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are gated by rst_i so they read as idle during the reset cycle itself
  assign axi_arready_o = !rst_i && (state_q == IDLE);
  assign axi_rvalid_o  = !rst_i && (state_q == DATA);
  assign axi_rlast_o   = axi_rvalid_o && last_beat;
  assign axi_rid_o     = axi_rvalid_o ? id_q : '0;
  assign axi_rresp_o   = (axi_rvalid_o && err_q) ? 2'b10 : 2'b00;
  assign axi_rdata_o   = (axi_rvalid_o && !err_q) ? (first_q ? ram_data_i : rdata_q) : 32'd0;
  assign ram_rd_o      = !rst_i && (state_q == FETCH) && !err_q;
  assign ram_addr_o    = rst_i ? '0 : addr_q[RAM_ADDR_W+1:2];

endmodule

// File: tb/tb_axi_rd_sram_bridge.sv
// Randomised bench for axi_rd_sram_bridge against a burst-level address/response model and an SRAM model.
module tb_axi_rd_sram_bridge;
  localparam int AW  = 14;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic           axi_arvalid_i = 1'b0;
  logic [31:0]    axi_araddr_i = '0;
  logic [IDW-1:0] axi_arid_i = '0;
  logic [7:0]     axi_arlen_i = '0;
  logic [1:0]     axi_arburst_i = '0;
  logic           axi_arready_o;
  logic           axi_rvalid_o;
  logic [31:0]    axi_rdata_o;
  logic [1:0]     axi_rresp_o;
  logic [IDW-1:0] axi_rid_o;
  logic           axi_rlast_o;
  logic           axi_rready_i = 1'b0;
  logic           ram_rd_o;
  logic [AW-1:0]  ram_addr_o;
  logic [31:0]    ram_data = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] mem [0:(1<<AW)-1];

  axi_rd_sram_bridge #(.RAM_ADDR_W(AW), .AXI_ID_W(IDW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .axi_arvalid_i(axi_arvalid_i), .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
    .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i), .axi_arready_o(axi_arready_o),
    .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o), .axi_rready_i(axi_rready_i),
    .ram_rd_o(ram_rd_o), .ram_addr_o(ram_addr_o), .ram_data_i(ram_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_rd_o) ram_data <= mem[ram_addr_o];

  function automatic bit legal_burst(input logic [1:0] bt, input logic [7:0] len);
    if (bt == 2'b11) return 1'b0;
    if (bt == 2'b10) begin
`ifdef AXI_RD_SRAM_BRIDGE_WRAP_EN
      return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`else
      return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  // Byte address of beat i, from the burst-type definitions
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                           input logic [1:0] bt, input int i);
    longint aa, sz, start;
    aa = longint'(a);
    sz = (longint'(len) + 1) * 4;
    if (bt == 2'b00) return a;
    if (bt == 2'b10 && legal_burst(bt, len)) begin
      start = aa - (aa % sz);
      return 32'(start + ((aa - start) + 4 * i) % sz);
    end
    return 32'(aa + 4 * i);
  endfunction

  task automatic do_burst(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt,
                          input logic [IDW-1:0] id, input int stall_pct, input int stall_beat,
                          input int abort_beat, input string nm);
    bit lg;
    int beat, fetch, hs_cyc, budget, n, stall_cnt;
    bit wait_first, done;
    logic [31:0] ea, ed;
    logic [AW-1:0] ew;
    logic [1:0] er;
    lg = legal_burst(bt, len);
    beat = 0; fetch = 0; stall_cnt = 0; wait_first = 1'b1; done = 1'b0;
    @(negedge clk);
    axi_arvalid_i = 1'b1; axi_araddr_i = a; axi_arid_i = id;
    axi_arlen_i = len; axi_arburst_i = bt; axi_rready_i = 1'b0;
    n = 0;
    while (!axi_arready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (axi_arready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ar_timeout: arready=%b, required 1", nm, axi_arready_o);
      axi_arvalid_i = 1'b0;
      return;
    end
    hs_cyc = cyc;
    budget = (int'(len) + 1) * 12 + 40;
    n = 0;
    @(negedge clk);
    axi_arvalid_i = 1'b0; axi_araddr_i = $urandom; axi_arlen_i = 8'($urandom);
    axi_arburst_i = 2'($urandom); axi_arid_i = IDW'($urandom);
    while (!done && n < budget) begin
      n++;
      checks++;
      if (axi_arready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s arready_busy beat %0d: arready=%b, required 0", nm, beat, axi_arready_o);
      end
      if (ram_rd_o) begin
        ea = beat_addr(a, len, bt, fetch);
        ew = ea[AW+1:2];
        checks++;
        if (!lg || axi_rvalid_o || ram_addr_o !== ew) begin
          errors++;
          $display("FAIL %s fetch %0d: ram_addr=%h rvalid=%b, required ram_addr=%h legal=%b no rvalid",
                   nm, fetch, ram_addr_o, axi_rvalid_o, ew, lg);
        end
        fetch++;
      end
      if (axi_rvalid_o) begin
        if (wait_first) begin
          checks++;
          if (cyc != hs_cyc + 2) begin
            errors++;
            $display("FAIL %s latency beat %0d: %0d cycles, required 2", nm, beat, cyc - hs_cyc);
          end
          wait_first = 1'b0;
        end
        ea = beat_addr(a, len, bt, beat);
        ed = lg ? mem[ea[AW+1:2]] : 32'd0;
        er = lg ? 2'b00 : 2'b10;
        checks++;
        if (axi_rdata_o !== ed || axi_rresp_o !== er || axi_rid_o !== id ||
            axi_rlast_o !== (beat == int'(len))) begin
          errors++;
          $display("FAIL %s beat %0d: data=%h resp=%b id=%h last=%b, required data=%h resp=%b id=%h last=%b",
                   nm, beat, axi_rdata_o, axi_rresp_o, axi_rid_o, axi_rlast_o,
                   ed, er, id, (beat == int'(len)));
        end
        if (beat == abort_beat) begin
          rst_i = 1'b1; axi_rready_i = 1'b0;
          #1;
          checks++;
          if ({axi_rvalid_o, axi_rlast_o, axi_arready_o, ram_rd_o} !== 4'b0 ||
              axi_rdata_o !== 32'd0 || axi_rresp_o !== 2'b00 || axi_rid_o !== '0 || ram_addr_o !== '0) begin
            errors++;
            $display("FAIL %s reset_outputs: rvalid=%b rlast=%b arready=%b rd=%b data=%h resp=%b id=%h addr=%h, required all 0",
                     nm, axi_rvalid_o, axi_rlast_o, axi_arready_o, ram_rd_o, axi_rdata_o,
                     axi_rresp_o, axi_rid_o, ram_addr_o);
          end
          @(negedge clk);
          rst_i = 1'b0;
          #1;
          checks++;
          if (axi_arready_o !== 1'b1 || axi_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s post_reset: arready=%b rvalid=%b, required 1 0", nm, axi_arready_o, axi_rvalid_o);
          end
          return;
        end
        if (beat == stall_beat && stall_cnt < 5) begin
          axi_rready_i = 1'b0;
          stall_cnt++;
        end else begin
          axi_rready_i = ($urandom_range(99) >= stall_pct);
        end
        if (axi_rready_i) begin
          hs_cyc = cyc;
          wait_first = 1'b1;
          beat++;
          if (beat == int'(len) + 1) done = 1'b1;
        end
      end else begin
        axi_rready_i = 1'($urandom_range(1));
      end
      @(negedge clk);
    end
    axi_rready_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s burst_timeout: %0d beats, required %0d", nm, beat, int'(len) + 1);
    end
    checks++;
    if (fetch != (lg ? int'(len) + 1 : 0)) begin
      errors++;
      $display("FAIL %s fetch_count: %0d, required %0d", nm, fetch, lg ? int'(len) + 1 : 0);
    end
    checks++;
    if (axi_rvalid_o !== 1'b0 || axi_arready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after: rvalid=%b arready=%b, required 0 1", nm, axi_rvalid_o, axi_arready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({axi_rvalid_o, axi_rlast_o, axi_arready_o, ram_rd_o} !== 4'b0 ||
        axi_rdata_o !== 32'd0 || axi_rresp_o !== 2'b00 || axi_rid_o !== '0 || ram_addr_o !== '0) begin
      errors++;
      $display("FAIL reset_state: rvalid=%b rlast=%b arready=%b rd=%b data=%h resp=%b id=%h addr=%h, required all 0",
               axi_rvalid_o, axi_rlast_o, axi_arready_o, ram_rd_o, axi_rdata_o, axi_rresp_o, axi_rid_o, ram_addr_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (axi_arready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: arready=%b, required 1", axi_arready_o);
    end
  endtask

  task automatic test_incr();
    do_burst(32'h8000_0010, 8'd3, 2'b01, 4'd5, 0, -1, -1, "incr");
  endtask

  task automatic test_wrap();
    do_burst(32'h8000_001C, 8'd3, 2'b10, 4'd9, 0, -1, -1, "wrap");
    do_burst(32'h0000_0134, 8'd7, 2'b10, 4'd2, 20, -1, -1, "wrap8");
    do_burst(32'h0000_0200, 8'd2, 2'b10, 4'd3, 0, -1, -1, "wrap_badlen");
  endtask

  task automatic test_backpressure();
    do_burst(32'h0000_1000, 8'd3, 2'b01, 4'd7, 0, 1, -1, "backpressure");
  endtask

  task automatic test_illegal();
    do_burst(32'h0000_0020, 8'd1, 2'b11, 4'd4, 0, -1, -1, "illegal");
  endtask

  task automatic test_reset_mid_burst();
    do_burst(32'h0000_0300, 8'd7, 2'b01, 4'd6, 0, -1, 2, "abort");
    do_burst(32'h0000_0400, 8'd0, 2'b01, 4'd1, 0, -1, -1, "after_abort");
  endtask

  task automatic test_fixed_256();
    do_burst(32'h0000_0040, 8'd255, 2'b00, 4'd12, 10, -1, -1, "fixed256");
  endtask

  task automatic test_random();
    logic [1:0] bt;
    logic [7:0] len;
    for (int k = 0; k < 25; k++) begin
      bt = 2'($urandom_range(3));
      if (bt == 2'b10 && $urandom_range(3) != 0) len = 8'((2 << $urandom_range(3)) - 1);
      else len = 8'($urandom_range(15));
      do_burst($urandom, len, bt, IDW'($urandom), 40, -1, -1, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_illegal();
    test_reset_mid_burst();
    test_fixed_256();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
